// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: byte-stream pattern in, byte-stream response out, optional capture.
// Optional MISR signature on sig_o when SCAN_CTRL_SIG_EN is defined.
module scan_chain_ctrl #(
    parameter int unsigned NREGS = 1918,
    parameter int unsigned CNTW  = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        capture_i,
    input  logic        abort_i,
    input  logic        pat_valid_i,
    input  logic [7:0]  pat_data_i,
    output logic        pat_ready_o,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    input  logic        rsp_ready_i,
    output logic        test_tm_o,
    output logic        test_se_o,
    output logic        scan_in_o,
    input  logic        scan_out_i,
    output logic        capture_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] sig_o
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NREGS - 1);
    localparam logic [CNTW-1:0] NREGS_C  = CNTW'(NREGS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SHIFT   = 3'd2,
        FLUSH   = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      pat_buf_q;
    logic [7:0]      rsp_buf_q;
    logic            rsp_valid_q;
    logic [2:0]      bit_q;
    logic [CNTW-1:0] cnt_q;
    logic            cap_q;
    logic            tm_q;
    logic            se;
    logic            pat_take;
    logic            aborting;
    logic            starting;
    logic            rsp_hs;

    assign aborting = abort_i && (state_q != IDLE);
    assign starting = start_i && (state_q == IDLE);
    assign rsp_hs   = rsp_valid_q && rsp_ready_i;

    // Next-state and shift/load strobes; abort overrides everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        se       = 1'b0;
        pat_take = 1'b0;
        case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD: begin
                if (pat_valid_i) begin
                    pat_take = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!rsp_valid_q) begin
                    se = 1'b1;
                    if (cnt_q == LAST_IDX)  state_d = FLUSH;
                    else if (bit_q == 3'd7) state_d = LOAD;
                end
            end
            FLUSH:   if (rsp_hs) state_d = cap_q ? CAPTURE : DONE;
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (aborting) begin
            state_d  = IDLE;
            se       = 1'b0;
            pat_take = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pat_buf_q   <= '0;
            rsp_buf_q   <= '0;
            rsp_valid_q <= 1'b0;
            bit_q       <= '0;
            cnt_q       <= '0;
            cap_q       <= 1'b0;
            tm_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (aborting) begin
                pat_buf_q   <= '0;
                rsp_buf_q   <= '0;
                rsp_valid_q <= 1'b0;
                bit_q       <= '0;
                cnt_q       <= '0;
                tm_q        <= 1'b0;
            end else begin
                if (starting) begin
                    cap_q     <= capture_i;
                    bit_q     <= '0;
                    cnt_q     <= '0;
                    tm_q      <= 1'b1;
                    pat_buf_q <= '0;
                end
                if (pat_take) pat_buf_q <= pat_data_i;
                // Byte is presented after bit 7 or after the chain's last flop.
                if (se) begin
                    rsp_buf_q[bit_q] <= scan_out_i;
                    bit_q            <= bit_q + 3'd1;
                    if (cnt_q < NREGS_C) cnt_q <= cnt_q + CNTW'(1);
                    if (bit_q == 3'd7 || cnt_q == LAST_IDX) rsp_valid_q <= 1'b1;
                end
                if (rsp_hs) begin
                    rsp_valid_q <= 1'b0;
                    rsp_buf_q   <= '0;
                end
                if (state_q == DONE) tm_q <= 1'b0;
            end
        end
    end

`ifdef SCAN_CTRL_SIG_EN
    logic [15:0] sig_q;

    // CRC-16-CCITT MISR over unloaded bits; held after DONE until next start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else if (starting) begin
            sig_q <= 16'hFFFF;
        end else if (se) begin
            sig_q <= {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ scan_out_i) ? 16'h1021 : 16'h0000);
        end
    end

    assign sig_o = sig_q;
`else
    assign sig_o = 16'h0000;
`endif

    assign pat_ready_o = pat_take;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_buf_q;
    assign test_tm_o   = tm_q;
    assign test_se_o   = se;
    assign scan_in_o   = (state_q == SHIFT) && pat_buf_q[bit_q];
    assign capture_o   = (state_q == CAPTURE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequences the CSOC scan chain: serialises a byte-stream test pattern into the chain and deserialises the unloaded response into a byte stream.
- Drives the chain's scan-enable, test-mode and serial input; samples the chain tail.
- Sits between the UART command/byte path and the CSOC scan pins.
- Supports shift-only and shift-then-capture sequences, with stall-free hold while either byte stream is blocked.

Parameters:
- NREGS, 1918: chain length in flops; shifts per pattern; ≥ 2.
- CNTW, 12: shift counter width; must satisfy 2^CNTW > NREGS.

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse; begins a sequence when idle
- capture_i  in  1  sampled with start_i; 1 = insert capture cycle after shift
- abort_i  in  1  cancels the sequence in progress
- pat_valid_i  in  1  pattern byte available
- pat_data_i  in  8  pattern byte, LSB shifted first
- pat_ready_o  out  1  pattern byte consumed this cycle
- rsp_valid_o  out  1  response byte available
- rsp_data_o  out  8  response byte, first-unloaded bit in LSB
- rsp_ready_i  in  1  response byte accepted
- test_tm_o  out  1  chain test mode
- test_se_o  out  1  scan enable; chain shifts exactly on cycles where this is 1
- scan_in_o  out  1  serial data into chain head
- scan_out_i  in  1  chain tail, valid before the shift edge
- capture_o  out  1  one-cycle functional capture strobe
- busy_o  out  1  sequence active
- done_o  out  1  one-cycle pulse at sequence end
- sig_o  out  16  response signature (optional feature)

Interface (already decided):
- One clock, clk_i.
- Reset is synchronous and active-high, rst_i.

Behaviour:
- Reset: state=IDLE; all outputs 0; counters 0; byte buffers empty.
- FSM states: IDLE, LOAD, SHIFT, FLUSH, CAPTURE, DONE.
- IDLE:
  - On start_i: latch capture_i, clear bit counter, test_tm_o←1, go to LOAD.
  - start_i while not IDLE is ignored.
- LOAD:
  - Wait for pat_valid_i; on acceptance (pat_ready_o=1 for one cycle), latch the byte into the shift buffer, go to SHIFT.
- SHIFT:
  - Each cycle with test_se_o=1: scan_in_o = buffer bit b; scan_out_i is stored into response buffer bit b; total count increments.
  - test_se_o is combinationally 0 (hold) when the response buffer is full and not yet drained; the chain holds.
  - After 8 bits, or at the final bit: present the response byte (rsp_valid_o=1).
  - After 8 bits and count<NREGS: return to LOAD.
  - count reaches NREGS → FLUSH.
- Final byte:
  - ceil(NREGS/8) pattern bytes are consumed; unused high bits of the last pattern byte are ignored.
  - Unused high bits of the last response byte are 0.
  - Default NREGS: 240 bytes; last byte carries 6 bits.
- Response handshake:
  - rsp_data_o is stable while rsp_valid_o=1 && !rsp_ready_i.
  - The byte is cleared on rsp_valid_o && rsp_ready_i.
- FLUSH:
  - Wait for the final response byte handshake.
  - Then go to CAPTURE if capture latched, else DONE.
- CAPTURE:
  - capture_o=1 for exactly one cycle with test_se_o=0 → DONE.
- DONE:
  - done_o=1 for one cycle; test_tm_o←0 → IDLE.
  - busy_o=1 in every state except IDLE.
- Shift-to-shift gap: each byte costs 1 LOAD cycle + 8 shift cycles minimum, so there are no bubbles beyond the LOAD cycle.
- abort_i (any non-IDLE state, priority over all other events):
  - Next cycle: IDLE, test_se_o=0, test_tm_o=0, rsp_valid_o=0, buffers cleared.
  - No done_o; chain contents are undefined to the host.
- Simultaneous start_i and abort_i in IDLE: start wins (abort meaningless in IDLE).
- Counter saturates at NREGS; never wraps.

Optional Feature:
- Macro SCAN_CTRL_SIG_EN.
- When defined:
  - 16-bit MISR over unloaded bits, CRC-16-CCITT polynomial x^16+x^12+x^5+1, shift-left, feedback = sig[15]^scan_out_i.
  - Initialised to 16'hFFFF on start acceptance; updated only on test_se_o=1 cycles.
  - sig_o holds its value after DONE until the next start.
- When undefined:
  - sig_o tied to 16'h0000; no MISR flops.

Test Plan:
- Reset: rst_i=1 for 2 cycles mid-SHIFT → all outputs 0, state IDLE, next start_i works normally.
- NREGS=10, shift-only: start_i with capture_i=0; pattern bytes 8'hA5, 8'h03; chain model preloaded 10'h2F1 → exactly 10 test_se_o cycles; scan_in_o sequence 1,0,1,0,0,1,0,1,1,1; responses 8'hF1, 8'h02; done_o pulse; no capture_o.
- NREGS=10, capture: capture_i=1 → capture_o single pulse after the last response handshake, with test_se_o=0 that cycle; done_o on the following cycle.
- Backpressure: hold rsp_ready_i=0 for 5 cycles after the first response byte → test_se_o=0 throughout the stall, rsp_data_o stable, shift count unchanged. Starve pat_valid_i for 4 cycles → stays in LOAD, test_se_o=0.
- Abort: abort_i after 4 shifts → next cycle busy_o=0, test_se_o=0, test_tm_o=0, rsp_valid_o=0, no done_o; a following start_i runs a complete sequence.
- SCAN_CTRL_SIG_EN defined, NREGS=10, unload all-zero chain → sig_o equals the reference CRC-16-CCITT of ten 0 bits from 16'hFFFF. Undefined → sig_o=16'h0000.
